// File: rtl/ps2_cmd_arbiter.sv
// rtl/ps2_cmd_arbiter.sv - round-robin PS/2 host command scheduler with quiet wait, response wait and retry
module ps2_cmd_arbiter #(
    parameter int QUIET_CYCLES = 5000,
    parameter int RESP_TIMEOUT = 2000000,
    parameter int MAX_RETRY    = 3
) (
    input  logic       ck,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic [7:0] cmd0,
    input  logic [7:0] cmd1,
    output logic [1:0] done,
    output logic [1:0] err,
    output logic       busy,
    input  logic       rd_busy,
    input  logic       wr_busy,
    output logic       wr_send,
    output logic [7:0] wr_data,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       fwd_valid,
    output logic [7:0] fwd_data
);

    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam int TW = $clog2(RESP_TIMEOUT + 1);

    localparam logic [7:0] BYTE_ACK    = 8'hFA;
    localparam logic [7:0] BYTE_RESEND = 8'hFE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_QUIET,
        S_SEND,
        S_WR_START,
        S_WR_END,
        S_RESP,
        S_DONE,
        S_FAIL
    } state_t;

    state_t          r_state;
    logic            r_last;       // requester served most recently
    logic            r_grant;      // requester owning the current transaction
    logic [2:0]      r_retry_cnt;
    logic [QW-1:0]   r_quiet_cnt;
    logic [TW-1:0]   r_tmo_cnt;
    logic [1:0]      r_done;
    logic [1:0]      r_err;
    logic            r_busy;
    logic            r_wr_send;
    logic [7:0]      r_wr_data;
    logic            r_fwd_valid;
    logic [7:0]      r_fwd_data;

    logic            w_line_idle;
    logic            w_rx_ack;
    logic            w_rx_resend;
    logic            w_consume;
    logic            w_timeout;
    logic            w_waiting;
    logic            w_attempt_fail;
    logic            w_can_retry;
    logic            w_pick;
    logic            w_quiet_done;

    assign w_line_idle  = !rd_busy && !wr_busy;
    assign w_rx_ack     = rx_valid && (rx_data == BYTE_ACK);
    assign w_rx_resend  = rx_valid && (rx_data == BYTE_RESEND);
    // Only the response window swallows ACK/RESEND; everything else belongs to the scan path.
    assign w_consume    = (r_state == S_RESP) && (w_rx_ack || w_rx_resend);
    assign w_timeout    = (r_tmo_cnt == TW'(RESP_TIMEOUT - 1));
    assign w_waiting    = (r_state == S_WR_START) || (r_state == S_WR_END);
    // A received byte in RESP masks a coincident timeout for that cycle.
    assign w_attempt_fail = (w_waiting && w_timeout) ||
                            ((r_state == S_RESP) && (rx_valid ? w_rx_resend : w_timeout));
    assign w_can_retry  = (r_retry_cnt < 3'(MAX_RETRY));
    // Single requester wins outright; with both pending, the one not served last wins.
    assign w_pick       = (req == 2'b11) ? ~r_last : req[1];
    assign w_quiet_done = w_line_idle && (r_quiet_cnt == QW'(QUIET_CYCLES - 1));

    // Transaction sequencer with registered outputs
    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_grant     <= 1'b0;
            r_retry_cnt <= '0;
            r_quiet_cnt <= '0;
            r_tmo_cnt   <= '0;
            r_done      <= 2'b00;
            r_err       <= 2'b00;
            r_busy      <= 1'b0;
            r_wr_send   <= 1'b0;
            r_wr_data   <= 8'h00;
        end else begin
            r_wr_send <= 1'b0;
            r_done    <= 2'b00;
            r_err     <= 2'b00;

            if ((w_waiting || (r_state == S_RESP)) && !w_timeout) begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end

            if (w_attempt_fail) begin
                if (w_can_retry) begin
                    r_retry_cnt <= r_retry_cnt + 3'd1;
                    r_quiet_cnt <= '0;
                    r_state     <= S_QUIET;
                end else begin
                    r_err   <= r_grant ? 2'b10 : 2'b01;
                    r_state <= S_FAIL;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (req != 2'b00) begin
                            r_grant     <= w_pick;
                            r_wr_data   <= w_pick ? cmd1 : cmd0;
                            r_retry_cnt <= '0;
                            r_quiet_cnt <= '0;
                            r_busy      <= 1'b1;
                            r_state     <= S_QUIET;
                        end
                    end
                    S_QUIET: begin
                        if (!w_line_idle) begin
                            r_quiet_cnt <= '0;
                        end else if (w_quiet_done) begin
                            r_wr_send <= 1'b1;
                            r_state   <= S_SEND;
                        end else begin
                            r_quiet_cnt <= r_quiet_cnt + QW'(1);
                        end
                    end
                    S_SEND: begin
                        r_tmo_cnt <= '0;
                        r_state   <= S_WR_START;
                    end
                    S_WR_START: begin
                        if (wr_busy) r_state <= S_WR_END;
                    end
                    S_WR_END: begin
                        if (!wr_busy) r_state <= S_RESP;
                    end
                    S_RESP: begin
                        if (w_rx_ack) begin
                            r_done  <= r_grant ? 2'b10 : 2'b01;
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE, S_FAIL: begin
                        r_last  <= r_grant;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Registered pass-through of reader bytes not consumed as a command response
    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            r_fwd_valid <= 1'b0;
            r_fwd_data  <= 8'h00;
        end else begin
            r_fwd_valid <= rx_valid && !w_consume;
            if (rx_valid && !w_consume) r_fwd_data <= rx_data;
        end
    end

    assign done      = r_done;
    assign err       = r_err;
    assign busy      = r_busy;
    assign wr_send   = r_wr_send;
    assign wr_data   = r_wr_data;
    assign fwd_valid = r_fwd_valid;
    assign fwd_data  = r_fwd_data;

endmodule
